// File: rtl/token_decoder.sv
// -----------------------------------------------------------------------------
// token_decoder
//   Detokenizer: reads a zero-terminated code stream and finds each code in the
//   codes table. It then walks the vocab RAM to that entry (entries are
//   zero-separated strings) and copies the entry's characters into the text RAM.
//   The text is terminated with a 0.
//   All memories are synchronous (1-cycle read latency). Each read uses two
//   cycles: an issue/wait state, then an evaluate state.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   cs           : start request, only looked at while idle
//   stream_addr  : code stream RAM read address      / stream_din : its data
//   ctab_addr    : codes table RAM read address      / ctab_din   : its data
//   vocab_addr   : vocab RAM read address            / vocab_din  : its data
//   text_addr    : text RAM write address
//   text_we      : text RAM write enable (one cycle per character)
//   text_dout    : character written to the text RAM
//   done         : sticky, decode finished with terminator written
//   err          : sticky, decode aborted
// -----------------------------------------------------------------------------
module token_decoder #(
    parameter int ADDR_WIDTH       = 4,
    parameter int VOCAB_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cs,
    output logic [ADDR_WIDTH-1:0]       stream_addr,
    input  logic [DATA_WIDTH-1:0]       stream_din,
    output logic [VOCAB_ADDR_WIDTH-1:0] ctab_addr,
    input  logic [DATA_WIDTH-1:0]       ctab_din,
    output logic [VOCAB_ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0]       vocab_din,
    output logic [ADDR_WIDTH-1:0]       text_addr,
    output logic                        text_we,
    output logic [DATA_WIDTH-1:0]       text_dout,
    output logic                        done,
    output logic                        err
);

    localparam logic [ADDR_WIDTH-1:0]       A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]       A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]       A_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [VOCAB_ADDR_WIDTH-1:0] V_ZERO = {VOCAB_ADDR_WIDTH{1'b0}};
    localparam logic [VOCAB_ADDR_WIDTH-1:0] V_ONE  = {{(VOCAB_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [VOCAB_ADDR_WIDTH-1:0] V_MAX  = {VOCAB_ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]       D_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH_W = 4'd1,
        ST_FETCH   = 4'd2,
        ST_LOOK_W  = 4'd3,
        ST_LOOK    = 4'd4,
        ST_SKIP_W  = 4'd5,
        ST_SKIP    = 4'd6,
        ST_COPY_W  = 4'd7,
        ST_COPY    = 4'd8,
        ST_TERM    = 4'd9,
        ST_DONE    = 4'd10,
        ST_ERR     = 4'd11
    } state_t;

    state_t                      state_r,      state_s;
    logic [ADDR_WIDTH-1:0]       stream_addr_r, stream_addr_s;
    logic [VOCAB_ADDR_WIDTH-1:0] ctab_addr_r,  ctab_addr_s;
    logic [VOCAB_ADDR_WIDTH-1:0] vocab_addr_r, vocab_addr_s;
    logic [ADDR_WIDTH-1:0]       text_addr_r,  text_addr_s;
    logic                        text_we_r,    text_we_s;
    logic [DATA_WIDTH-1:0]       text_dout_r,  text_dout_s;
    logic                        done_r,       done_s;
    logic                        err_r,        err_s;
    logic [DATA_WIDTH-1:0]       code_r,       code_s;
    logic [VOCAB_ADDR_WIDTH-1:0] idx_r,        idx_s;
    logic [VOCAB_ADDR_WIDTH-1:0] sep_r,        sep_s;
    logic [VOCAB_ADDR_WIDTH-1:0] sep_inc_s;

    // State and datapath registers; every output is taken straight from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            stream_addr_r <= A_ZERO;
            ctab_addr_r   <= V_ZERO;
            vocab_addr_r  <= V_ZERO;
            text_addr_r   <= A_ZERO;
            text_we_r     <= 1'b0;
            text_dout_r   <= D_ZERO;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            code_r        <= D_ZERO;
            idx_r         <= V_ZERO;
            sep_r         <= V_ZERO;
        end else begin
            state_r       <= state_s;
            stream_addr_r <= stream_addr_s;
            ctab_addr_r   <= ctab_addr_s;
            vocab_addr_r  <= vocab_addr_s;
            text_addr_r   <= text_addr_s;
            text_we_r     <= text_we_s;
            text_dout_r   <= text_dout_s;
            done_r        <= done_s;
            err_r         <= err_s;
            code_r        <= code_s;
            idx_r         <= idx_s;
            sep_r         <= sep_s;
        end
    end

    // Next-state and next-register logic for the decode sequence.
    always_comb begin
        state_s       = state_r;
        stream_addr_s = stream_addr_r;
        ctab_addr_s   = ctab_addr_r;
        vocab_addr_s  = vocab_addr_r;
        text_addr_s   = text_addr_r;
        text_we_s     = 1'b0;
        text_dout_s   = text_dout_r;
        code_s        = code_r;
        idx_s         = idx_r;
        sep_s         = sep_r;
        sep_inc_s     = sep_r + V_ONE;

        case (state_r)
            ST_IDLE: begin
                if (cs) begin
                    state_s = ST_FETCH_W;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH_W: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (stream_din == D_ZERO) begin
                    // Terminator is driven during the TERM cycle.
                    state_s     = ST_TERM;
                    text_we_s   = 1'b1;
                    text_dout_s = D_ZERO;
                end else begin
                    code_s      = stream_din;
                    ctab_addr_s = V_ZERO;
                    state_s     = ST_LOOK_W;
                end
            end
            ST_LOOK_W: begin
                state_s = ST_LOOK;
            end
            ST_LOOK: begin
                if (ctab_din == code_r) begin
                    idx_s        = ctab_addr_r;
                    vocab_addr_s = V_ZERO;
                    sep_s        = V_ZERO;
                    // Entry 0 starts at vocab offset 0: nothing to skip.
                    if (ctab_addr_r == V_ZERO) begin
                        state_s = ST_COPY_W;
                    end else begin
                        state_s = ST_SKIP_W;
                    end
                end else if ((ctab_din == D_ZERO) || (ctab_addr_r == V_MAX)) begin
                    state_s = ST_ERR;
                end else begin
                    ctab_addr_s = ctab_addr_r + V_ONE;
                    state_s     = ST_LOOK_W;
                end
            end
            ST_SKIP_W: begin
                state_s = ST_SKIP;
            end
            ST_SKIP: begin
                if (vocab_addr_r == V_MAX) begin
                    state_s = ST_ERR;
                end else begin
                    vocab_addr_s = vocab_addr_r + V_ONE;
                    if (vocab_din == D_ZERO) begin
                        sep_s = sep_inc_s;
                        // Having passed idx separators, the next byte opens the entry.
                        if (sep_inc_s == idx_r) begin
                            state_s = ST_COPY_W;
                        end else begin
                            state_s = ST_SKIP_W;
                        end
                    end else begin
                        state_s = ST_SKIP_W;
                    end
                end
            end
            ST_COPY_W: begin
                // A write is in flight this cycle. Writing the last slot means the
                // terminator can never fit, so the decode aborts.
                if (text_we_r && (text_addr_r == A_MAX)) begin
                    state_s = ST_ERR;
                end else if (text_we_r) begin
                    text_addr_s = text_addr_r + A_ONE;
                    state_s     = ST_COPY;
                end else begin
                    state_s = ST_COPY;
                end
            end
            ST_COPY: begin
                if (vocab_din != D_ZERO) begin
                    if (vocab_addr_r == V_MAX) begin
                        state_s = ST_ERR;
                    end else begin
                        text_we_s    = 1'b1;
                        text_dout_s  = vocab_din;
                        vocab_addr_s = vocab_addr_r + V_ONE;
                        state_s      = ST_COPY_W;
                    end
                end else if (stream_addr_r == A_MAX) begin
                    // Stream RAM exhausted: close the text instead of wrapping.
                    text_we_s   = 1'b1;
                    text_dout_s = D_ZERO;
                    state_s     = ST_TERM;
                end else begin
                    stream_addr_s = stream_addr_r + A_ONE;
                    state_s       = ST_FETCH_W;
                end
            end
            ST_TERM: begin
                state_s = ST_DONE;
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_ERR;
            end
        endcase

        done_s = done_r | (state_s == ST_DONE);
        err_s  = err_r  | (state_s == ST_ERR);
    end

    assign stream_addr = stream_addr_r;
    assign ctab_addr   = ctab_addr_r;
    assign vocab_addr  = vocab_addr_r;
    assign text_addr   = text_addr_r;
    assign text_we     = text_we_r;
    assign text_dout   = text_dout_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule
